vga_layer_mixer: RTL

//  Parametrised N-layer pixel compositor for the VGA pipeline. Sits after draw_background, in place of the

---
 rtl/vga_layer_mixer.sv | 115 +++++++++++
 1 files changed

// File: rtl/vga_layer_mixer.sv
// -----------------------------------------------------------------------------
// vga_layer_mixer
//
// N-layer pixel compositor for the VGA pipeline. It places NUM_LAYERS overlay
// layers over a background colour using fixed priority, where the highest layer
// index wins. During blanking the output pixel is forced to black. Every timing
// and sync signal is delayed by the same PIPE_DEPTH cycles so that the outputs
// stay aligned. Layer enables only take effect on the rising edge of vsync, so
// a frame never shows a mask change part way through. A frame counter counts
// vsync rising edges.
//
// Optional feature (compile-time macro):
//   VGA_MIX_COLOR_KEY_EN - when defined, a layer pixel equal to KEY_COLOR is
//                          treated as transparent. Such a pixel falls through
//                          to the next lower layer, or to the background.
//
// Ports:
//   pclk, rst_n        pixel clock, asynchronous active-low reset
//   hcount/vcount_in   beam position (CNT_W bits)
//   hsync/vsync_in     sync inputs
//   hblnk/vblnk_in     blanking inputs
//   bg_rgb_in          background pixel
//   layer_rgb_in       layer k colour at [k*RGB_W +: RGB_W]
//   layer_valid_in     layer k covers the current pixel
//   layer_en           requested enable mask, sampled at each vsync rise
//   *_out              inputs delayed by PIPE_DEPTH cycles
//   rgb_out            composited pixel, PIPE_DEPTH cycles after its inputs
//   frame_cnt          vsync_in rising edges since reset (wraps)
// -----------------------------------------------------------------------------
module vga_layer_mixer #(
  parameter int                    NUM_LAYERS  = 4,
  parameter int                    RGB_W       = 12,
  parameter int                    CNT_W       = 11,
  parameter int                    PIPE_DEPTH  = 2,
  parameter int                    FRAME_CNT_W = 16,
  parameter logic [RGB_W-1:0]      KEY_COLOR   = 12'h0F0
) (
  input  logic                        pclk,
  input  logic                        rst_n,
  input  logic [CNT_W-1:0]            hcount_in,
  input  logic [CNT_W-1:0]            vcount_in,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic                        hblnk_in,
  input  logic                        vblnk_in,
  input  logic [RGB_W-1:0]            bg_rgb_in,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb_in,
  input  logic [NUM_LAYERS-1:0]       layer_valid_in,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  output logic [CNT_W-1:0]            hcount_out,
  output logic [CNT_W-1:0]            vcount_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        hblnk_out,
  output logic                        vblnk_out,
  output logic [RGB_W-1:0]            rgb_out,
  output logic [FRAME_CNT_W-1:0]      frame_cnt
);

`ifdef VGA_MIX_COLOR_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  // One pipeline word: {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}
  localparam int SW = 2*CNT_W + 4 + RGB_W;

  logic [NUM_LAYERS-1:0] en_active;   // mask in force for the current frame
  logic                  vsync_prev;
  logic                  vsync_edge;
  logic [RGB_W-1:0]      mix_rgb;
  logic [SW-1:0]         pipe [PIPE_DEPTH];

  assign vsync_edge = vsync_in & ~vsync_prev;

  // Priority mux. Layers are scanned from lowest to highest, so a later (higher)
  // hit overrides an earlier one. When KEY_EN is 0 the key term folds away.
  always_comb begin
    mix_rgb = bg_rgb_in;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (layer_valid_in[k] && en_active[k] &&
          (!KEY_EN || (layer_rgb_in[k*RGB_W +: RGB_W] != KEY_COLOR)))
        mix_rgb = layer_rgb_in[k*RGB_W +: RGB_W];
    end
    if (hblnk_in || vblnk_in)
      mix_rgb = '0;
  end

  // pipe[0] holds stage 1. Each later entry is a plain delay of the one before.
  // en_active updates on the edge cycle itself. The pixel sampled in that same
  // cycle therefore still sees the old mask.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++)
        pipe[i] <= '0;
      en_active  <= '1;
      vsync_prev <= 1'b1;   // vsync held high through reset is not an edge
      frame_cnt  <= '0;
    end else begin
      pipe[0] <= {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, mix_rgb};
      for (int i = 1; i < PIPE_DEPTH; i++)
        pipe[i] <= pipe[i-1];
      vsync_prev <= vsync_in;
      if (vsync_edge) begin
        en_active <= layer_en;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} =
    pipe[PIPE_DEPTH-1];

endmodule
